// File: rtl/tape_frame_seq_pkg.sv
// -----------------------------------------------------------------------------
// tape_frame_seq_pkg
// Shared types and constants for the tape frame sequencer.
//   state_e : sequencer FSM states
//   phase_e : which part of the frame is being sent (leader, sync, payload)
//   LEAD_BYTE_DEF / SYNC_BYTE_DEF : default leader and sync byte values
// -----------------------------------------------------------------------------
package tape_frame_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        GUARD,
        WAIT,
        FINISH
    } state_e;

    typedef enum logic [1:0] {
        LEADER,
        SYNC,
        PAYLOAD
    } phase_e;

    localparam logic [7:0] LEAD_BYTE_DEF = 8'h16;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'h24;

endpackage

// File: rtl/tape_frame_seq_watchdog.sv
// -----------------------------------------------------------------------------
// tape_watchdog
// 24-bit cycle counter used to time out a byte that the serializer never
// finishes.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears the count
//   clr   : synchronous clear of the count (has priority over en)
//   en    : count this cycle
//   tc    : terminal count; high in the TIMEOUT-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module tape_watchdog #(
    parameter logic [23:0] TIMEOUT = 24'd8388607
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [23:0] count_q;
    logic [23:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 24'd1;
        end
    end

    // count_q holds the number of enabled cycles already completed, so the
    // cycle that sees TIMEOUT-1 is the TIMEOUT-th one.
    assign tc = en && !clr && (count_q == TIMEOUT - 24'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tape_frame_seq.sv
// -----------------------------------------------------------------------------
// tape_frame_seq
// Sequences one tape frame (leader bytes, one sync byte, payload bytes) into
// an external bit serializer, one byte at a time, with a per-byte watchdog.
//   clk, reset         : clock and synchronous active-high reset
//   go, abort          : one-cycle pulses that start / cancel a frame
//   slow               : speed select sampled at go (1 = STP_SLOW)
//   in_data/valid/last : payload stream; in_ready accepts a byte
//   sg_start/din/stp   : start pulse, byte and step value to the serializer
//   sg_done            : serializer finished the current byte (level)
//   motor, busy        : tape motor enable / frame in progress
//   frame_done         : one-cycle pulse on normal end of frame
//   error              : sticky timeout flag, cleared by the next go
// -----------------------------------------------------------------------------
module tape_frame_seq
    import tape_frame_seq_pkg::*;
#(
    parameter logic [15:0] LEADER_LEN = 16'd259,
    parameter logic [7:0]  LEAD_BYTE  = LEAD_BYTE_DEF,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter logic [23:0] STP_FAST   = 24'd20140,
    parameter logic [23:0] STP_SLOW   = 24'd10070,
    parameter logic [23:0] TIMEOUT    = 24'd8388607
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        abort,
    input  logic        slow,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        sg_start,
    output logic [7:0]  sg_din,
    output logic [23:0] sg_stp,
    input  logic        sg_done,
    output logic        motor,
    output logic        busy,
    output logic        frame_done,
    output logic        error
);

    state_e      state_q,      state_d;
    phase_e      phase_q,      phase_d;
    logic [15:0] lead_cnt_q,   lead_cnt_d;
    logic [7:0]  byte_q,       byte_d;
    logic        last_q,       last_d;
    logic [23:0] stp_q,        stp_d;
    logic        motor_q,      motor_d;
    logic        busy_q,       busy_d;
    logic        error_q,      error_d;
    logic        frame_done_q, frame_done_d;

    logic wd_en;
    logic wd_clr;
    logic wd_tc;

    // The watchdog only runs while waiting on the serializer and restarts
    // from zero for every byte.
    assign wd_en  = (state_q == WAIT);
    assign wd_clr = (state_q != WAIT);

    tape_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .tc    (wd_tc)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statements can leave one unassigned and infer a latch.
        state_d      = state_q;
        phase_d      = phase_q;
        lead_cnt_d   = lead_cnt_q;
        byte_d       = byte_q;
        last_d       = last_q;
        stp_d        = stp_q;
        motor_d      = motor_q;
        busy_d       = busy_q;
        error_d      = error_q;
        frame_done_d = 1'b0;

        if (state_q == IDLE) begin
            if (go && !abort) begin
                stp_d      = slow ? STP_SLOW : STP_FAST;
                error_d    = 1'b0;
                motor_d    = 1'b1;
                busy_d     = 1'b1;
                lead_cnt_d = '0;
                // An empty leader goes straight to the sync byte.
                phase_d    = (LEADER_LEN == 16'd0) ? SYNC : LEADER;
                state_d    = FETCH;
            end
        end else if (abort) begin
            // Abort beats everything, including a same-cycle sg_done, and
            // leaves the error flag alone.
            motor_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                FETCH: begin
                    unique case (phase_q)
                        LEADER: begin
                            byte_d  = LEAD_BYTE;
                            state_d = START;
                        end
                        SYNC: begin
                            byte_d  = SYNC_BYTE;
                            state_d = START;
                        end
                        PAYLOAD: begin
                            // Underrun: hold here with the motor running.
                            if (in_valid) begin
                                byte_d  = in_data;
                                last_d  = in_last;
                                state_d = START;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
                START: state_d = GUARD;
                // The serializer drops done one cycle after start, so done is
                // not looked at until WAIT.
                GUARD: state_d = WAIT;
                WAIT: begin
                    if (sg_done) begin
                        state_d = FINISH;
                    end else if (wd_tc) begin
                        error_d = 1'b1;
                        motor_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                FINISH: begin
                    unique case (phase_q)
                        LEADER: begin
                            lead_cnt_d = lead_cnt_q + 16'd1;
                            if (lead_cnt_q + 16'd1 == LEADER_LEN) begin
                                phase_d = SYNC;
                            end
                            state_d = FETCH;
                        end
                        SYNC: begin
                            phase_d = PAYLOAD;
                            state_d = FETCH;
                        end
                        PAYLOAD: begin
                            if (last_q) begin
                                frame_done_d = 1'b1;
                                motor_d      = 1'b0;
                                busy_d       = 1'b0;
                                state_d      = IDLE;
                            end else begin
                                state_d = FETCH;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= LEADER;
            lead_cnt_q   <= '0;
            byte_q       <= '0;
            last_q       <= 1'b0;
            stp_q        <= STP_FAST;
            motor_q      <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            phase_q      <= phase_d;
            lead_cnt_q   <= lead_cnt_d;
            byte_q       <= byte_d;
            last_q       <= last_d;
            stp_q        <= stp_d;
            motor_q      <= motor_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            frame_done_q <= frame_done_d;
        end
    end

    // sg_start decodes START directly, so an abort seen in START still lets
    // that single pulse go out.
    assign sg_start   = (state_q == START);
    assign in_ready   = (state_q == FETCH) && (phase_q == PAYLOAD);
    assign sg_din     = byte_q;
    assign sg_stp     = stp_q;
    assign motor      = motor_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_tape_frame_seq.sv
// -----------------------------------------------------------------------------
// tb_tape_frame_seq
// Directed bench for tape_frame_seq. dut_a runs LEADER_LEN=3, TIMEOUT=100;
// dut_b runs LEADER_LEN=0 and shares the stimulus. Each DUT has a simple
// serializer model that raises done SER_DELAY cycles after sg_start.
// -----------------------------------------------------------------------------
module tb_tape_frame_seq;

    localparam logic [23:0] STP_FAST  = 24'd20140;
    localparam logic [23:0] STP_SLOW  = 24'd10070;
    localparam int          SER_DELAY = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        slow = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        ser_en = 1'b1;
    logic        done_force = 1'b0;

    logic        in_ready_a, sg_start_a, motor_a, busy_a, frame_done_a, error_a;
    logic [7:0]  sg_din_a;
    logic [23:0] sg_stp_a;
    logic        ser_done_a = 1'b0;
    logic        sg_done_a;
    int          ser_cnt_a = 0;

    logic        in_ready_b, sg_start_b, motor_b, busy_b, frame_done_b, error_b;
    logic [7:0]  sg_din_b;
    logic [23:0] sg_stp_b;
    logic        ser_done_b = 1'b0;
    int          ser_cnt_b = 0;

    int          start_cnt_a = 0;
    int          fd_cnt_a = 0;
    int          start_cnt_b = 0;
    logic [7:0]  din_a[$];
    logic [23:0] stp_a[$];
    logic [7:0]  din_b[$];

    int          n_assert = 0;
    int          n_fail = 0;

    assign sg_done_a = ser_done_a | done_force;

    always #5 clk = ~clk;

    tape_frame_seq #(
        .LEADER_LEN (16'd3),
        .TIMEOUT    (24'd100)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .abort      (abort),
        .slow       (slow),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready_a),
        .sg_start   (sg_start_a),
        .sg_din     (sg_din_a),
        .sg_stp     (sg_stp_a),
        .sg_done    (sg_done_a),
        .motor      (motor_a),
        .busy       (busy_a),
        .frame_done (frame_done_a),
        .error      (error_a)
    );

    tape_frame_seq #(
        .LEADER_LEN (16'd0)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .abort      (abort),
        .slow       (slow),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready_b),
        .sg_start   (sg_start_b),
        .sg_din     (sg_din_b),
        .sg_stp     (sg_stp_b),
        .sg_done    (ser_done_b),
        .motor      (motor_b),
        .busy       (busy_b),
        .frame_done (frame_done_b),
        .error      (error_b)
    );

    // Serializer models and output monitors, evaluated mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            ser_cnt_a  = 0;
            ser_done_a = 1'b0;
            ser_cnt_b  = 0;
            ser_done_b = 1'b0;
        end else begin
            if (sg_start_a) begin
                ser_done_a = 1'b0;
                ser_cnt_a  = SER_DELAY;
                start_cnt_a++;
                din_a.push_back(sg_din_a);
                stp_a.push_back(sg_stp_a);
            end else if (ser_cnt_a != 0) begin
                ser_cnt_a--;
                if (ser_cnt_a == 0 && ser_en) ser_done_a = 1'b1;
            end
            if (sg_start_b) begin
                ser_done_b = 1'b0;
                ser_cnt_b  = SER_DELAY;
                start_cnt_b++;
                din_b.push_back(sg_din_b);
            end else if (ser_cnt_b != 0) begin
                ser_cnt_b--;
                if (ser_cnt_b == 0 && ser_en) ser_done_b = 1'b1;
            end
            if (frame_done_a) fd_cnt_a++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running, required $finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic clear_mon();
        start_cnt_a = 0;
        fd_cnt_a    = 0;
        start_cnt_b = 0;
        din_a.delete();
        stp_a.delete();
        din_b.delete();
    endtask

    task automatic check_rst(input string who, input logic mo, input logic bu, input logic rdy,
                             input logic st, input logic fd, input logic er,
                             input logic [7:0] din, input logic [23:0] stp);
        check({who, " motor"},      {31'd0, mo},  32'd0);
        check({who, " busy"},       {31'd0, bu},  32'd0);
        check({who, " in_ready"},   {31'd0, rdy}, 32'd0);
        check({who, " sg_start"},   {31'd0, st},  32'd0);
        check({who, " frame_done"}, {31'd0, fd},  32'd0);
        check({who, " error"},      {31'd0, er},  32'd0);
        check({who, " sg_din"},     {24'd0, din}, 32'h00);
        check({who, " sg_stp"},     {8'd0, stp},  {8'd0, STP_FAST});
    endtask

    task automatic wait_fd_a(input int budget);
        int i = 0;
        while (fd_cnt_a == 0 && i < budget) begin
            tick();
            i++;
        end
    endtask

    task automatic wait_ready_a(input int budget);
        int i = 0;
        while (!in_ready_a && i < budget) begin
            tick();
            i++;
        end
    endtask

    initial begin
        logic [7:0] exp1[5];
        logic       flag;
        int         n;
        exp1 = '{8'h16, 8'h16, 8'h16, 8'h24, 8'hA5};

        // Reset state.
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check_rst("rst_a", motor_a, busy_a, in_ready_a, sg_start_a, frame_done_a,
                  error_a, sg_din_a, sg_stp_a);

        // Test 1: three leader bytes, sync, one payload byte.
        clear_mon();
        in_data = 8'hA5; in_valid = 1'b1; in_last = 1'b1; slow = 1'b0;
        pulse_go();
        check("t1 motor after go", {31'd0, motor_a}, 32'd1);
        check("t1 busy after go",  {31'd0, busy_a},  32'd1);
        flag = 1'b0;
        n = 0;
        while (fd_cnt_a == 0 && n < 2000) begin
            if (!motor_a) flag = 1'b1;
            tick();
            n++;
        end
        check("t1 frame_done seen", fd_cnt_a, 32'd1);
        check("t1 motor held",      {31'd0, flag}, 32'd0);
        check("t1 byte count",      din_a.size(), 32'd5);
        for (int k = 0; k < 5; k++) check($sformatf("t1 sg_din[%0d]", k), {24'd0, din_a[k]}, {24'd0, exp1[k]});
        check("t1 motor off", {31'd0, motor_a}, 32'd0);
        check("t1 busy off",  {31'd0, busy_a},  32'd0);
        check("t1 sg_stp",    {8'd0, sg_stp_a}, {8'd0, STP_FAST});
        tick(20);
        check("t1 single frame_done", fd_cnt_a, 32'd1);

        // Test 2: payload underrun after sync.
        clear_mon();
        in_valid = 1'b0; in_last = 1'b0;
        pulse_go();
        wait_ready_a(1000);
        check("t2 in_ready reached", {31'd0, in_ready_a}, 32'd1);
        check("t2 starts before stall", start_cnt_a, 32'd4);
        flag = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!in_ready_a || sg_start_a || !motor_a) flag = 1'b1;
            tick();
        end
        check("t2 stall clean", {31'd0, flag}, 32'd0);
        check("t2 no start in stall", start_cnt_a, 32'd4);
        in_data = 8'h3C; in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        wait_fd_a(500);
        check("t2 frame_done", fd_cnt_a, 32'd1);
        check("t2 payload byte", {24'd0, din_a[4]}, 32'h3C);

        // Test 3: serializer never finishes, TIMEOUT=100.
        clear_mon();
        ser_en = 1'b0;
        pulse_go();
        n = 0;
        while (!sg_start_a && n < 20) begin
            tick();
            n++;
        end
        check("t3 first start", {31'd0, sg_start_a}, 32'd1);
        n = 0;
        while (!error_a && n < 300) begin
            tick();
            n++;
        end
        // START and GUARD precede the first WAIT cycle.
        check("t3 wait cycles to error", n - 2, 32'd100);
        check("t3 busy",  {31'd0, busy_a},  32'd0);
        check("t3 motor", {31'd0, motor_a}, 32'd0);
        tick(5);
        check("t3 error sticky",   {31'd0, error_a}, 32'd1);
        check("t3 no frame_done",  fd_cnt_a, 32'd0);

        // Test 4: abort plus sg_done in the second leader byte's WAIT.
        clear_mon();
        ser_en = 1'b1;
        pulse_go();
        check("t4 error cleared by go", {31'd0, error_a}, 32'd0);
        n = 0;
        while (start_cnt_a < 2 && n < 300) begin
            tick();
            n++;
        end
        check("t4 second start", start_cnt_a, 32'd2);
        tick(10);
        abort = 1'b1; done_force = 1'b1;
        tick();
        abort = 1'b0; done_force = 1'b0;
        check("t4 motor", {31'd0, motor_a}, 32'd0);
        check("t4 busy",  {31'd0, busy_a},  32'd0);
        tick(150);
        check("t4 no further start", start_cnt_a, 32'd2);
        check("t4 no frame_done",    fd_cnt_a, 32'd0);
        check("t4 error unchanged",  {31'd0, error_a}, 32'd0);

        // Test 5: slow latched at go, toggled during the frame.
        clear_mon();
        in_data = 8'h5A; in_valid = 1'b1; in_last = 1'b1; slow = 1'b1;
        pulse_go();
        flag = 1'b0;
        n = 0;
        while (fd_cnt_a == 0 && n < 2000) begin
            slow = ~slow;
            if (sg_stp_a !== STP_SLOW) flag = 1'b1;
            tick();
            n++;
        end
        check("t5 frame_done",    fd_cnt_a, 32'd1);
        check("t5 sg_stp steady", {31'd0, flag}, 32'd0);
        check("t5 byte count",    stp_a.size(), 32'd5);
        for (int k = 0; k < stp_a.size(); k++) check($sformatf("t5 stp[%0d]", k), {8'd0, stp_a[k]}, {8'd0, STP_SLOW});

        // Test 6: reset during a payload stall, then LEADER_LEN=0 frame.
        clear_mon();
        in_valid = 1'b0; in_last = 1'b0; slow = 1'b1;
        pulse_go();
        wait_ready_a(1000);
        tick(5);
        check("t6 stalled", {31'd0, in_ready_a}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_rst("t6_a", motor_a, busy_a, in_ready_a, sg_start_a, frame_done_a,
                  error_a, sg_din_a, sg_stp_a);
        check_rst("t6_b", motor_b, busy_b, in_ready_b, sg_start_b, frame_done_b,
                  error_b, sg_din_b, sg_stp_b);
        tick(5);
        check("t6 no start after reset", start_cnt_a, 32'd4);
        clear_mon();
        slow = 1'b0;
        pulse_go();
        n = 0;
        while (start_cnt_b < 1 && n < 20) begin
            tick();
            n++;
        end
        check("t6 b first start", start_cnt_b, 32'd1);
        check("t6 b first sg_din", {24'd0, din_b[0]}, 32'h24);
        check("t6 b sg_stp", {8'd0, sg_stp_b}, {8'd0, STP_FAST});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
